// File: rtl/alu_rr_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_rr_scheduler_if                                           |
// | Brief    : Request / shared-ALU / response bundle for alu_rr_scheduler    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*2-1:0]      req_op;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [1:0]                alu_op;
  logic [DATA_W-1:0]         alu_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_flag;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flag
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flag
  );
endinterface
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_rr_scheduler                                              |
// | Brief    : Round-robin sharing of one external ALU among NUM_REQ clients  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input wire                 clk,
  input wire                 rst_n,
  alu_rr_scheduler_if.slave  bus
);
  localparam int              ID_W      = $clog2(NUM_REQ);
  localparam logic [ID_W:0]   C_NUM     = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ID_W-1:0]      r_ptr, r_gnt, r_id, w_win;
  logic [DATA_W-1:0]    r_a, r_b, r_res, w_a, w_b;
  logic [1:0]           r_op, w_op;
  logic                 r_flag, w_flag;
  logic                 w_any, w_accept, w_done;
  logic [NUM_REQ-1:0]   w_ready;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [ID_W:0]        w_off, w_idx;
  logic [DATA_W:0]      w_sum;

  // Rotating the doubled valid vector by ptr makes bit 0 the highest-priority slot.
  always_comb begin : arbiter
    w_rot = {bus.req_valid, bus.req_valid} >> r_ptr;
    w_any = |bus.req_valid;
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = (ID_W+1)'(i);
    end
    w_idx = {1'b0, r_ptr} + w_off;
    if (w_idx >= C_NUM) w_idx = w_idx - C_NUM;
    w_win = w_idx[ID_W-1:0];
    w_a   = '0;
    w_b   = '0;
    w_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_a  = bus.req_a[i*DATA_W +: DATA_W];
        w_b  = bus.req_b[i*DATA_W +: DATA_W];
        w_op = bus.req_op[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant is gated by rst_n so no requester sees ready while reset is held.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && rst_n) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = (w_win == ID_W'(i));
          end
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin : flag_calc
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_flag = 1'b0;
    case (r_op)
      2'b00:   w_flag = w_sum[DATA_W];
      2'b01:   w_flag = (r_a < r_b);
      default: w_flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_gnt  <= '0;
      r_ptr  <= '0;
      r_id   <= '0;
      r_res  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_op  <= w_op;
        r_gnt <= w_win;
      end
      if (r_state == S_EXEC) begin
        r_res  <= bus.alu_result;
        r_flag <= w_flag;
        r_id   <= r_gnt;
      end
      if (w_done) r_ptr <= (r_gnt == C_LAST_ID) ? '0 : r_gnt + 1'b1;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_op     = r_op;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_res;
  assign bus.rsp_flag   = r_flag;
endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_rr_scheduler                                           |
// | Brief    : Randomised self-checking bench with transaction-level model    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_rr_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [N-1:0]  tb_valid = '0;
  logic [DW-1:0] tb_a [N];
  logic [DW-1:0] tb_b [N];
  logic [1:0]    tb_op[N];
  logic          tb_rsp_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  always_comb begin
    bus.req_valid = tb_valid;
    bus.rsp_ready = tb_rsp_ready;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = tb_a[i];
      bus.req_b[i*DW +: DW] = tb_b[i];
      bus.req_op[i*2 +: 2]  = tb_op[i];
    end
  end

  // External shared ALU
  always_comb begin
    case (bus.alu_op)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_result = bus.alu_a - bus.alu_b;
      2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic void ref_alu(input int a, input int b, input int op, output int r, output int f);
    case (op)
      0:       begin r = (a + b) % (1 << DW);            f = ((a + b) >= (1 << DW)) ? 1 : 0; end
      1:       begin r = (a - b + (1 << DW)) % (1 << DW); f = (a < b) ? 1 : 0; end
      2:       begin r = a & b; f = 0; end
      default: begin r = a | b; f = 0; end
    endcase
  endfunction

  task automatic fill(input int i);
    tb_a[i]  = DW'($urandom);
    tb_b[i]  = DW'($urandom);
    tb_op[i] = 2'($urandom_range(0, 3));
  endtask

  // Drives one request/response exchange and reports what was observed; callers judge it.
  task automatic txn(input logic [N-1:0] drop, input int stall,
                     output logic [N-1:0] rdy, output int a, output int b, output int op,
                     output int lat, output int id, output int res, output int flag,
                     output bit busy_bad, output bit stable_bad, output bit tmo);
    int k, w;
    rdy = '0; a = 0; b = 0; op = 0; lat = 0; id = 0; res = 0; flag = 0;
    busy_bad = 0; stable_bad = 0; tmo = 0; k = 0; w = 0;
    #1;
    while (bus.req_ready == '0 && k < 20) begin @(negedge clk); k++; end
    if (bus.req_ready == '0) begin tmo = 1; return; end
    rdy = bus.req_ready;
    for (int i = 0; i < N; i++) if (rdy[i]) w = i;
    a = int'(tb_a[w]); b = int'(tb_b[w]); op = int'(tb_op[w]);
    @(posedge clk); #1;
    tb_valid = tb_valid & ~drop;
    fill(w);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.req_ready != '0) busy_bad = 1;
      @(negedge clk); lat++;
    end
    if (!bus.rsp_valid) begin tmo = 1; return; end
    if (bus.req_ready != '0) busy_bad = 1;
    id = int'(bus.rsp_id); res = int'(bus.rsp_result); flag = int'(bus.rsp_flag);
    if (stall > 0) begin
      tb_rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.req_ready != '0) busy_bad = 1;
        if (int'(bus.rsp_id) != id || int'(bus.rsp_result) != res || int'(bus.rsp_flag) != flag)
          stable_bad = 1;
      end
      tb_rsp_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [N-1:0] rdy; int a, b, op, lat, id, res, flag; bit bb, sb, tmo; int k;
    for (int i = 0; i < N; i++) fill(i);
    tb_valid = '1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flag} !== '0) begin n_fail++;
      $display("FAIL reset_rsp got v=%b id=%0d r=%0d f=%b exp all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flag); end
    n_checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin n_fail++;
      $display("FAIL reset_alu got a=%0d b=%0d op=%0d exp 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    tb_valid = '0;
    rst_n = 1'b1; model_ptr = 0;
    @(negedge clk);
    tb_valid = 4'b0100; tb_a[2] = 8'd3; tb_b[2] = 8'd4; tb_op[2] = 2'b00;
    txn(4'b0100, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
    n_checks++; if (id !== 2 || res !== 7 || tmo) begin n_fail++; $display("FAIL reset_pre_txn got id=%0d res=%0d exp id=2 res=7", id, res); end
    model_ptr = 3;
    // Launch requester 3 and reset while its operation is in EXEC
    tb_valid = 4'b1000; tb_a[3] = 8'd9; tb_b[3] = 8'd2; tb_op[3] = 2'b01;
    k = 0; #1;
    while (bus.req_ready == '0 && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    tb_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin n_fail++;
      $display("FAIL reset_midexec_ctrl got v=%b rdy=%b exp 0", bus.rsp_valid, bus.req_ready); end
    n_checks++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin n_fail++;
      $display("FAIL reset_midexec_data got id=%0d r=%0d f=%b a=%0d exp 0", bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.alu_a); end
    @(negedge clk); rst_n = 1'b1; model_ptr = 0;
    k = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) k++; end
    n_checks++; if (k !== 0) begin n_fail++; $display("FAIL reset_discard got %0d rsp_valid cycles exp 0", k); end
    for (int i = 0; i < N; i++) fill(i);
    tb_valid = '1;
    txn('1, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
    n_checks++; if (rdy !== 4'b0001 || tmo) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", rdy); end
    model_ptr = 1;
  endtask

  task automatic test_single_add();
    logic [N-1:0] rdy; int a, b, op, lat, id, res, flag; bit bb, sb, tmo;
    tb_valid = 4'b0100; tb_a[2] = 8'd10; tb_b[2] = 8'd5; tb_op[2] = 2'b00;
    txn(4'b0100, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
    n_checks++; if (rdy !== 4'b0100 || tmo) begin n_fail++; $display("FAIL add_grant got=%b exp=0100", rdy); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d exp=2", lat); end
    n_checks++; if (id !== 2 || res !== 15 || flag !== 0) begin n_fail++;
      $display("FAIL add_rsp got id=%0d res=%0d flag=%0d exp 2/15/0", id, res, flag); end
    model_ptr = 3;
  endtask

  task automatic test_corner_ops();
    logic [N-1:0] rdy; int a, b, op, lat, id, res, flag; bit bb, sb, tmo; int r;
    int ta[5] = '{255, 5, 10, 170, 170};
    int tbv[5] = '{1, 10, 5, 204, 204};
    int top[5] = '{0, 1, 1, 2, 3};
    int er[5] = '{0, 251, 5, 136, 238};
    int ef[5] = '{1, 1, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      r = $urandom_range(0, N - 1);
      tb_valid = '0; tb_valid[r] = 1'b1;
      tb_a[r] = DW'(ta[k]); tb_b[r] = DW'(tbv[k]); tb_op[r] = 2'(top[k]);
      txn('1, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
      n_checks++; if (id !== r || res !== er[k] || flag !== ef[k] || tmo) begin n_fail++;
        $display("FAIL corner_op%0d got id=%0d res=%0d flag=%0d exp %0d/%0d/%0d", k, id, res, flag, r, er[k], ef[k]); end
      model_ptr = (r + 1) % N;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rdy, drop; int a, b, op, lat, id, res, flag, xr, xf; bit bb, sb, tmo;
    int order[6] = '{0, 1, 2, 3, 0, 2};
    @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_ptr = 0;
    for (int i = 0; i < N; i++) fill(i);
    tb_valid = '1;
    for (int k = 0; k < 6; k++) begin
      drop = (k == 1) ? 4'b0010 : ((k == 5) ? 4'b1111 : 4'b0000);
      txn(drop, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
      ref_alu(a, b, op, xr, xf);
      n_checks++; if (rdy !== (N'(1) << order[k]) || id !== order[k] || tmo) begin n_fail++;
        $display("FAIL rr_order%0d got rdy=%b id=%0d exp id=%0d", k, rdy, id, order[k]); end
      n_checks++; if (res !== xr || flag !== xf) begin n_fail++;
        $display("FAIL rr_result%0d got %0d/%0d exp %0d/%0d", k, res, flag, xr, xf); end
      model_ptr = (order[k] + 1) % N;
    end
    tb_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy; int a, b, op, lat, id, res, flag, xr, xf, w; bit bb, sb, tmo;
    for (int i = 0; i < N; i++) fill(i);
    tb_valid = 4'b1001;
    w = rr_pick(tb_valid, model_ptr);
    txn('0, 5, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
    ref_alu(a, b, op, xr, xf);
    n_checks++; if (bb !== 1'b0 || sb !== 1'b0 || tmo) begin n_fail++;
      $display("FAIL bp_hold got busy_bad=%b unstable=%b exp 0/0", bb, sb); end
    n_checks++; if (id !== w || res !== xr || flag !== xf) begin n_fail++;
      $display("FAIL bp_rsp got %0d/%0d/%0d exp %0d/%0d/%0d", id, res, flag, w, xr, xf); end
    model_ptr = (w + 1) % N;
    #1;
    w = rr_pick(tb_valid, model_ptr);
    n_checks++; if (bus.req_ready !== (N'(1) << w)) begin n_fail++;
      $display("FAIL bp_next_accept got rdy=%b exp=%b", bus.req_ready, N'(1) << w); end
    txn('1, 0, rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
    n_checks++; if (id !== w || tmo) begin n_fail++; $display("FAIL bp_drain got id=%0d exp=%0d", id, w); end
    model_ptr = (w + 1) % N;
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, nv; int a, b, op, lat, id, res, flag, xr, xf, w; bit bb, sb, tmo;
    for (int it = 0; it < 40; it++) begin
      nv = N'($urandom_range(0, (1 << N) - 1));
      if ((tb_valid | nv) == '0) nv = N'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) if (nv[i] && !tb_valid[i]) fill(i);
      tb_valid = tb_valid | nv;
      w = rr_pick(tb_valid, model_ptr);
      txn(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3),
          rdy, a, b, op, lat, id, res, flag, bb, sb, tmo);
      ref_alu(a, b, op, xr, xf);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL rnd%0d_timeout got timeout exp response", it); end
      n_checks++; if (rdy !== (N'(1) << w)) begin n_fail++; $display("FAIL rnd%0d_grant got=%b exp=%b", it, rdy, N'(1) << w); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=2", it, lat); end
      n_checks++; if (id !== w) begin n_fail++; $display("FAIL rnd%0d_id got=%0d exp=%0d", it, id, w); end
      n_checks++; if (res !== xr) begin n_fail++; $display("FAIL rnd%0d_result got=%0d exp=%0d op=%0d", it, res, xr, op); end
      n_checks++; if (flag !== xf) begin n_fail++; $display("FAIL rnd%0d_flag got=%0d exp=%0d op=%0d", it, flag, xf, op); end
      n_checks++; if (bb !== 1'b0 || sb !== 1'b0) begin n_fail++;
        $display("FAIL rnd%0d_hold got busy_bad=%b unstable=%b exp 0/0", it, bb, sb); end
      model_ptr = (w + 1) % N;
    end
    tb_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin tb_a[i] = '0; tb_b[i] = '0; tb_op[i] = '0; end
    test_reset();
    test_single_add();
    test_corner_ops();
    test_round_robin();
    test_backpressure();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200us");
    $fatal(1);
  end
endmodule
`default_nettype wire
